pingpong_vec_loader: RTL

PINGPONG_VEC_LOADER -- requirements
Module: pingpong_vec_loader

---
 rtl/pingpong_pkg.sv | 19 +
 rtl/vec_bank.sv | 33 +++
 rtl/pingpong_vec_loader.sv | 122 ++++++++++++
 3 files changed

// File: rtl/pingpong_pkg.sv
// Shared types and defaults for the ping-pong vector loader.
// Optional flush port: define LOADER_FLUSH_EN.
package pingpong_pkg;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    FILLING = 2'd1,
    FULL    = 2'd2
  } bank_state_t;

  localparam int DEF_DIMENSION = 16;
  localparam int DEF_WIDTH     = 8;
  localparam int DEF_IDX_W     = $clog2(DEF_DIMENSION);

  function automatic int idx_w(input int d);
    return (d > 1) ? $clog2(d) : 1;
  endfunction

endpackage

// File: rtl/vec_bank.sv
// One vector register: indexed element write plus
// zero-pad of every element at or above idx.
module vec_bank
  import pingpong_pkg::*;
#(
  parameter int DIMENSION = DEF_DIMENSION,
  parameter int WIDTH     = DEF_WIDTH,
  parameter int IW        = DEF_IDX_W
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              we,
  input  logic                              pad,
  input  logic [IW-1:0]                     idx,
  input  logic signed [WIDTH-1:0]           din,
  output logic signed [DIMENSION*WIDTH-1:0] data
);

  // A write at idx wins over the pad, so padding lands above it.
  always_ff @(posedge clk) begin
    if (rst) begin
      data <= '0;
    end else begin
      for (int i = 0; i < DIMENSION; i++) begin
        if (we && (IW'(i) == idx))
          data[i*WIDTH +: WIDTH] <= din;
        else if (pad && (IW'(i) >= idx))
          data[i*WIDTH +: WIDTH] <= '0;
      end
    end
  end

endmodule

// File: rtl/pingpong_vec_loader.sv
// Double-buffered serial-to-vector loader with ack handshake.
// Optional flush port: define LOADER_FLUSH_EN.
module pingpong_vec_loader
  import pingpong_pkg::*;
#(
  parameter int DIMENSION = DEF_DIMENSION,
  parameter int WIDTH     = DEF_WIDTH
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              en,
`ifdef LOADER_FLUSH_EN
  input  logic                              flush,
`endif
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic signed [WIDTH-1:0]           in_data,
  output logic signed [DIMENSION*WIDTH-1:0] data1,
  output logic signed [DIMENSION*WIDTH-1:0] data2,
  output logic                              select_sig,
  output logic                              vec_valid,
  input  logic                              vec_ack,
  output logic [1:0]                        occupancy
);

  localparam int IW = idx_w(DIMENSION);
  localparam logic [IW-1:0] LAST = IW'(DIMENSION - 1);

  bank_state_t st [2];
  bank_state_t st_n [2];
  logic wr_bank, rd_bank, wr_n, rd_n;
  logic [IW-1:0] idx, idx_n;
  logic acc, ack, fl, done, vv_n;
  logic [1:0] occ_n;

  assign in_ready = en && (st[wr_bank] != FULL);
  assign acc = in_valid && in_ready;
  assign ack = vec_ack && vec_valid;

`ifdef LOADER_FLUSH_EN
  assign fl = en && flush && (st[wr_bank] == FILLING);
`else
  assign fl = 1'b0;
`endif

  assign done = (acc && (idx == LAST)) || fl;

  // Ack and write never target the same bank: one needs FULL,
  // the other needs not-FULL.
  always_comb begin
    st_n  = st;
    wr_n  = wr_bank;
    rd_n  = rd_bank;
    idx_n = idx;
    if (ack) begin
      st_n[rd_bank] = EMPTY;
      rd_n = ~rd_bank;
    end
    if (done) begin
      st_n[wr_bank] = FULL;
      wr_n  = ~wr_bank;
      idx_n = '0;
    end else if (acc) begin
      st_n[wr_bank] = FILLING;
      idx_n = idx + IW'(1);
    end
    vv_n  = (st_n[rd_n] == FULL);
    occ_n = {1'b0, st_n[0] == FULL}
          + {1'b0, st_n[1] == FULL};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st[0]      <= EMPTY;
      st[1]      <= EMPTY;
      wr_bank    <= 1'b0;
      rd_bank    <= 1'b0;
      idx        <= '0;
      vec_valid  <= 1'b0;
      select_sig <= 1'b0;
      occupancy  <= 2'd0;
    end else begin
      st[0]      <= st_n[0];
      st[1]      <= st_n[1];
      wr_bank    <= wr_n;
      rd_bank    <= rd_n;
      idx        <= idx_n;
      vec_valid  <= vv_n;
      select_sig <= rd_n;
      occupancy  <= occ_n;
    end
  end

  vec_bank #(
    .DIMENSION(DIMENSION),
    .WIDTH    (WIDTH),
    .IW       (IW)
  ) u_bank0 (
    .clk (clk),
    .rst (rst),
    .we  (acc && !wr_bank),
    .pad (fl && !wr_bank),
    .idx (idx),
    .din (in_data),
    .data(data1)
  );

  vec_bank #(
    .DIMENSION(DIMENSION),
    .WIDTH    (WIDTH),
    .IW       (IW)
  ) u_bank1 (
    .clk (clk),
    .rst (rst),
    .we  (acc && wr_bank),
    .pad (fl && wr_bank),
    .idx (idx),
    .din (in_data),
    .data(data2)
  );

endmodule
